// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder / sequencer over a W-bit index that wraps at LAST.
// Optional build macro DECODER_SEQ_DOWN_EN adds a dir input that makes step count down.
module decoder_seq #(
   parameter int W    = 3,
   parameter int LAST = 2**W-1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            load,
   input  logic [W-1:0]    i,
   input  logic            step,
`ifdef DECODER_SEQ_DOWN_EN
   input  logic            dir,
`endif
   output logic [2**W-1:0] d,
   output logic [W-1:0]    idx,
   output logic            wrap
);
   localparam int N = 2**W;
   localparam logic [W-1:0] last_c = LAST[W-1:0];
   localparam logic [N-1:0] one_c  = {{(N-1){1'b0}}, 1'b1};
   logic [W-1:0] idx_d, idx_q;
   logic [N-1:0] d_d, d_q;
   logic         wrap_d, wrap_q;
   // next index and wrap: load beats step, step wraps to 0 past LAST (or to LAST when counting down)
   always_comb begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
      if (load) begin
         idx_d = i;
      end else if (step) begin
`ifdef DECODER_SEQ_DOWN_EN
         if (dir) begin
            wrap_d = (idx_q == '0) || (idx_q > last_c);
            idx_d  = wrap_d ? last_c : idx_q - 1'b1;
         end else begin
            wrap_d = idx_q >= last_c;
            idx_d  = wrap_d ? '0 : idx_q + 1'b1;
         end
`else
         wrap_d = idx_q >= last_c;
         idx_d  = wrap_d ? '0 : idx_q + 1'b1;
`endif
      end
      d_d = en ? (one_c << idx_d) : '0;
   end
   // state registers; decode is taken from the next index so d tracks idx with no extra stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         d_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         d_q    <= d_d;
         wrap_q <= wrap_d;
      end
   end
   assign idx  = idx_q;
   assign d    = d_q;
   assign wrap = wrap_q;
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: randomized and directed checks of decoder_seq for LAST=7, 4 and 0 against a reference model.
module tb_decoder_seq;
   logic       clk = 1'b0;
   logic       rst_n, en, load, step;
   logic [2:0] i;
`ifdef DECODER_SEQ_DOWN_EN
   logic       dir = 1'b0;
`endif
   logic [7:0] d_o [3];
   logic [2:0] idx_o [3];
   logic       wrap_o [3];
   int         lasts [3] = '{7, 4, 0};
   int         m_idx [3];
   int         m_wrap [3];
   int         m_d [3];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   decoder_seq #(.W(3), .LAST(7)) dut7 (.clk(clk), .rst_n(rst_n), .en(en), .load(load), .i(i), .step(step),
`ifdef DECODER_SEQ_DOWN_EN
      .dir(dir),
`endif
      .d(d_o[0]), .idx(idx_o[0]), .wrap(wrap_o[0]));
   decoder_seq #(.W(3), .LAST(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en), .load(load), .i(i), .step(step),
`ifdef DECODER_SEQ_DOWN_EN
      .dir(dir),
`endif
      .d(d_o[1]), .idx(idx_o[1]), .wrap(wrap_o[1]));
   decoder_seq #(.W(3), .LAST(0)) dut0 (.clk(clk), .rst_n(rst_n), .en(en), .load(load), .i(i), .step(step),
`ifdef DECODER_SEQ_DOWN_EN
      .dir(dir),
`endif
      .d(d_o[2]), .idx(idx_o[2]), .wrap(wrap_o[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_idx[k] = 0; m_wrap[k] = 0; m_d[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int l, nxt, w;
         l = lasts[k]; nxt = m_idx[k]; w = 0;
         if (load) nxt = int'(i);
         else if (step) begin
`ifdef DECODER_SEQ_DOWN_EN
            if (dir) begin
               if (m_idx[k] == 0 || m_idx[k] > l) begin nxt = l; w = 1; end
               else nxt = m_idx[k] - 1;
            end else
`endif
            if (m_idx[k] >= l) begin nxt = 0; w = 1; end
            else nxt = (m_idx[k] + 1) % 8;
         end
         m_idx[k] = nxt; m_wrap[k] = w; m_d[k] = en ? (1 << nxt) : 0;
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("idx_L%0d", lasts[k]), 32'(idx_o[k]), m_idx[k]);
         chk($sformatf("d_L%0d", lasts[k]), 32'(d_o[k]), m_d[k]);
         chk($sformatf("wrap_L%0d", lasts[k]), 32'(wrap_o[k]), m_wrap[k]);
         chk($sformatf("onehot_L%0d", lasts[k]), 32'($countones(d_o[k]) <= 1), 1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step(); else model_reset();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic e, input logic l, input logic [2:0] v, input logic s);
      en = e; load = l; i = v; step = s;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; load = 1'b1; i = 3'd5; step = 1'b0;
      model_reset();
      #3;
      compare_all();
      @(posedge clk); #1;
      compare_all();
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("first_load_d", 32'(d_o[0]), 32'h20);
      for (int v = 0; v < 8; v++) drive(1'b1, 1'b1, 3'(v), 1'b0);
      drive(1'b1, 1'b1, 3'd6, 1'b0);
      for (int n = 0; n < 3; n++) drive(1'b1, 1'b0, 3'd0, 1'b1);
      drive(1'b1, 1'b1, 3'd3, 1'b0);
      for (int n = 0; n < 3; n++) drive(1'b1, 1'b0, 3'd0, 1'b1);
      drive(1'b1, 1'b1, 3'd2, 1'b1);
      drive(1'b0, 1'b0, 3'd0, 1'b1);
      drive(1'b1, 1'b0, 3'd0, 1'b0);
      chk("reenable_d", 32'(d_o[0]), 32'h08);
      drive(1'b1, 1'b1, 3'd6, 1'b0);
      @(negedge clk); rst_n = 1'b0; model_reset();
      #1;
      compare_all();
      @(posedge clk); #1;
      compare_all();
      @(negedge clk); rst_n = 1'b1;
      drive(1'b1, 1'b0, 3'd0, 1'b1);
`ifdef DECODER_SEQ_DOWN_EN
      dir = 1'b1;
      drive(1'b1, 1'b1, 3'd1, 1'b0);
      drive(1'b1, 1'b0, 3'd0, 1'b1);
      drive(1'b1, 1'b0, 3'd0, 1'b1);
      drive(1'b1, 1'b1, 3'd3, 1'b0);
      dir = 1'b0;
      drive(1'b1, 1'b0, 3'd0, 1'b1);
`endif
      for (int n = 0; n < 400; n++) begin
`ifdef DECODER_SEQ_DOWN_EN
         dir = 1'($urandom_range(0, 1));
`endif
         drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
